// File: rtl/register_file_mp.sv
// Multi-read-port register file: one byte-masked write port and NUM_RD registered
// read ports with optional same-cycle write bypass and hardwired-zero entry 0.
module register_file_mp #(
  parameter int WIDTH     = 32,
  parameter int N         = 32,
  parameter int NUM_RD    = 2,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG0 = 1,
  localparam int AW       = $clog2(N),
  localparam int NB       = WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    write_en,
  input  logic [AW-1:0]           write_addr,
  input  logic [NB-1:0]           write_mask,
  input  logic [WIDTH-1:0]        data_in,
  input  logic [NUM_RD-1:0]       read_en,
  input  logic [NUM_RD*AW-1:0]    read_addr,
  output logic [NUM_RD*WIDTH-1:0] data_out,
  output logic [NUM_RD-1:0]       data_out_valid
);

  logic [WIDTH-1:0] mem_q [N];
  logic             wr_ok;
  logic [WIDTH-1:0] wr_cur;
  logic [WIDTH-1:0] wr_merged;

  // The merged word is shared by the storage update and the bypass path.
  always_comb begin
    wr_ok  = write_en && (int'(write_addr) < N) &&
             !((ZERO_REG0 != 0) && (write_addr == '0));
    wr_cur = (int'(write_addr) < N) ? mem_q[write_addr] : '0;
    for (int b = 0; b < NB; b++)
      wr_merged[8*b +: 8] = write_mask[b] ? data_in[8*b +: 8] : wr_cur[8*b +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[write_addr] <= wr_merged;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]    ra;
    logic             rd_ok;
    logic [WIDTH-1:0] rdata_d;
    logic [WIDTH-1:0] data_q;
    logic             vld_q;

    assign ra = read_addr[p*AW +: AW];

    always_comb begin
      rd_ok   = (int'(ra) < N) && !((ZERO_REG0 != 0) && (ra == '0));
      rdata_d = '0;
      if (rd_ok) begin
        if ((BYPASS != 0) && wr_ok && (write_addr == ra)) rdata_d = wr_merged;
        else                                              rdata_d = mem_q[ra];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        vld_q <= read_en[p];
        if (read_en[p]) data_q <= rdata_d;
      end
    end

    assign data_out[p*WIDTH +: WIDTH] = data_q;
    assign data_out_valid[p]          = vld_q;
  end

endmodule
